// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the FIFO-fed UART transmitter
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    localparam int DEFAULT_BAUD_DIV = 208;
    localparam int BAUD_CNT_W       = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - modulo-BAUD_DIV counter with synchronous clear
// tick marks the last cycle of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(BAUD_DIV - 1);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    assign tick = ~clr & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the FIFO and sends them as UART frames
// txd is registered, so the line lags the state register by one cycle.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_emp,
    input  logic [WIDTH-1:0] fifo_rd,
    output logic             fifo_re,
    output logic             txd,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] LAST_BIT  = 4'(WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic             txd_q, txd_d;
    logic             done_q, done_d;
    logic             tick;
    logic             baud_clr;

    // Hold the baud counter at zero until the start bit so every bit is a full period.
    assign baud_clr = (state_q == IDLE) | (state_q == LOAD);

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    assign fifo_re = (state_q == IDLE) & en & ~fifo_emp & ~rst;
    assign busy    = (state_q != IDLE);
    assign txd     = txd_q;
    assign done    = done_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        txd_d   = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_re) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = fifo_rd;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                txd_d = 1'b0;
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                // bit_q is reused here to count stop bits.
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

endmodule
